// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: 32-step MULT/MULTU/DIV/DIVU sequencer that borrows the
// shared execute ALU through the alu_* port set; results land in hi/lo.
// Ports: clk, rst (sync, active high), start/op/op_signed/src_a/src_b in;
//   busy/done/dbz/hi/lo out; alu_req/alu_a/alu_b/alu_mode1-3 out, alu_c in.
// Optional: define MULDIV_SIGNED_EN to honour op_signed (sign-magnitude wrap).
module alu_muldiv_seq #(
  parameter int STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic        op_signed,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic        dbz,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        alu_req,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_mode1,
  output logic [1:0]  alu_mode2,
  output logic        alu_mode3,
  input  logic [31:0] alu_c
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  // x: acc / rem, y: mq / quo, z: mc / dv
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic [31:0] z_q, z_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        dbz_q, dbz_d;
  // neg: negate product/quotient; rneg: negate remainder
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;

  logic        sa, sb;
  logic [31:0] ma, mb;

`ifdef MULDIV_SIGNED_EN
  assign sa = op_signed & src_a[31];
  assign sb = op_signed & src_b[31];
`else
  logic sig_unused;
  assign sig_unused = op_signed;
  assign sa = 1'b0;
  assign sb = 1'b0;
`endif

  assign ma = sa ? (~src_a + 32'd1) : src_a;
  assign mb = sb ? (~src_b + 32'd1) : src_b;

  logic [31:0] r;
  logic        top;
  logic        cy, bw;
  logic [31:0] nx, ny;
  logic [63:0] prod;
  logic [31:0] qf, rf;

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign alu_req   = busy;
  assign alu_mode1 = 2'b00;
  assign alu_mode2 = 2'b00;
  assign alu_mode3 = busy & op_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbz       = dbz_q;

  assign r   = {x_q[30:0], y_q[31]};
  assign top = x_q[31];

  assign alu_a = busy ? (op_q ? r : x_q) : 32'd0;
  assign alu_b = busy ? z_q : 32'd0;

  // carry/borrow rebuilt from operand and result sign bits
  assign cy = (alu_a[31] & alu_b[31]) |
              ((alu_a[31] | alu_b[31]) & ~alu_c[31]);
  assign bw = (~alu_a[31] & alu_b[31]) |
              ((~alu_a[31] | alu_b[31]) & alu_c[31]);

  always_comb begin
    nx = x_q;
    ny = y_q;
    if (op_q) begin
      nx = (top | ~bw) ? alu_c : r;
      ny = {y_q[30:0], top | ~bw};
    end else if (y_q[0]) begin
      nx = {cy, alu_c[31:1]};
      ny = {alu_c[0], y_q[31:1]};
    end else begin
      nx = {1'b0, x_q[31:1]};
      ny = {x_q[0], y_q[31:1]};
    end
  end

  always_comb begin
    prod = {nx, ny};
    if (neg_q) prod = ~prod + 64'd1;
    qf = neg_q  ? (~ny + 32'd1) : ny;
    rf = rneg_q ? (~nx + 32'd1) : nx;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          cnt_d  = 5'd0;
          neg_d  = sa ^ sb;
          rneg_d = sa;
          if (op && src_b == 32'd0) begin
            state_d = DONE;
            hi_d    = src_a;
            lo_d    = 32'hFFFF_FFFF;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            x_d     = 32'd0;
            y_d     = op ? ma : mb;
            z_d     = op ? mb : ma;
          end
        end
      end
      RUN: begin
        x_d   = nx;
        y_d   = ny;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(STEPS - 1)) begin
          state_d = DONE;
          dbz_d   = 1'b0;
          if (op_q) begin
            hi_d = rf;
            lo_d = qf;
          end else begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 1'b0;
      x_q     <= 32'd0;
      y_q     <= 32'd0;
      z_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      dbz_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: random + directed check of alu_muldiv_seq against
// an arithmetic reference; the shared ALU is modelled as a plain add/sub.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, op, op_signed;
  logic [31:0] src_a, src_b;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;
  logic        alu_req;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [1:0]  alu_mode1, alu_mode2;
  logic        alu_mode3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign alu_c = alu_mode3 ? (alu_a - alu_b) : (alu_a + alu_b);

  alu_muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .op_signed(op_signed), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo),
    .alu_req(alu_req), .alu_a(alu_a), .alu_b(alu_b),
    .alu_mode1(alu_mode1), .alu_mode2(alu_mode2),
    .alu_mode3(alu_mode3), .alu_c(alu_c)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic o, input logic s,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh,
                                output logic [31:0] el,
                                output logic ed);
    logic [63:0] p;
    longint sa, sb;
    logic use_s;
`ifdef MULDIV_SIGNED_EN
    use_s = s;
`else
    use_s = 1'b0;
`endif
    sa = use_s ? longint'($signed(a)) : longint'({32'd0, a});
    sb = use_s ? longint'($signed(b)) : longint'({32'd0, b});
    ed = 1'b0;
    if (o && b == 32'd0) begin
      eh = a;
      el = 32'hFFFF_FFFF;
      ed = 1'b1;
    end else if (!o) begin
      p  = 64'(sa * sb);
      eh = p[63:32];
      el = p[31:0];
    end else begin
      p  = 64'(sa / sb);
      el = p[31:0];
      p  = 64'(sa % sb);
      eh = p[31:0];
    end
  endfunction

  task automatic do_op(input logic o, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input int extra_at);
    logic [31:0] eh, el;
    logic        ed;
    int lat = 0, busybad = 0, m3bad = 0;
    model(o, s, a, b, eh, el, ed);
    @(negedge clk);
    start = 1'b1; op = o; op_signed = s; src_a = a; src_b = b;
    @(posedge clk);
    #1;
    start = 1'b0; src_a = $urandom; src_b = $urandom;
    op = ~o; op_signed = $urandom_range(0, 1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy || !alu_req) busybad++;
      if (alu_mode3 !== o) m3bad++;
      if (k == extra_at) begin
        start = 1'b1; src_a = $urandom; src_b = $urandom;
      end
    end
    chk("latency", 64'(lat), ed ? 64'd1 : 64'd33);
    chk("hi", {32'd0, hi}, {32'd0, eh});
    chk("lo", {32'd0, lo}, {32'd0, el});
    chk("dbz", {63'd0, dbz}, {63'd0, ed});
    chk("busy_run", 64'(busybad), 64'd0);
    chk("mode3", 64'(m3bad), 64'd0);
    @(negedge clk);
    chk("done_pulse", {62'd0, done, busy}, 64'd0);
    chk("alu_idle", {alu_a, alu_b}, 64'd0);
    chk("hi_hold", {hi, lo}, {eh, el});
  endtask

  initial begin
    int ndone;
    logic o;
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b0; op = 1'b0; op_signed = 1'b0;
    src_a = 32'd0; src_b = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out", {busy, done, dbz, alu_req, alu_mode3, 59'd0}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_alu", {alu_a, alu_b}, 64'd0);
    chk("rst_modes", {60'd0, alu_mode1, alu_mode2}, 64'd0);

    do_op(1'b0, 1'b0, 32'd7, 32'd6, 0);
    do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(1'b1, 1'b0, 32'd100, 32'd7, 0);
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'd3, 0);
    do_op(1'b1, 1'b0, 32'd5, 32'd0, 0);
    do_op(1'b1, 1'b0, 32'd9, 32'd3, 0);
    do_op(1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 10);
    do_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    do_op(1'b1, 1'b0, 32'd3, 32'hFFFF_FFFF, 0);
`ifdef MULDIV_SIGNED_EN
    do_op(1'b0, 1'b1, -32'sd7, 32'd3, 0);
    do_op(1'b1, 1'b1, -32'sd7, 32'd2, 0);
    do_op(1'b1, 1'b1, 32'd7, -32'sd2, 0);
    do_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 0);
`endif

    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if (!o && b == 32'd0) b = $urandom;
      do_op(o, 1'($urandom_range(0, 1)), a, b, 0);
    end

    @(negedge clk);
    start = 1'b1; op = 1'b1; op_signed = 1'b0;
    src_a = 32'd1000; src_b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", {62'd0, busy, done}, 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("rst_no_done", 64'(ndone), 64'd0);
    do_op(1'b1, 1'b0, 32'd1000, 32'd7, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU.
- Does not instantiate its own adder: borrows the shared 32-bit ALU through an external port set, iterating a shift-add multiply or restoring divide for 32 steps.
- Results go to HI/LO output registers.
- Sits beside the execute stage. The pipeline ALU-input mux grants the ALU to this block while alu_req is high.

Parameters:
- STEPS, 32, iteration count; equals the operand width. Fixed at 32; other values unsupported.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request pulse; sampled only in IDLE
- op  in  1  0 = multiply, 1 = divide
- op_signed  in  1  signed operation request (honoured only with the optional feature)
- src_a  in  32  multiplicand / dividend
- src_b  in  32  multiplier / divisor
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; hi/lo valid from this cycle onward
- dbz  out  1  divide-by-zero flag; updated with done
- hi  out  32  HI register (product upper word / remainder)
- lo  out  32  LO register (product lower word / quotient)
- alu_req  out  1  equals busy; pipeline must route alu_* to the ALU
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_mode1  out  2  ALU unit select; always 2'b00 (adder)
- alu_mode2  out  2  always 2'b00
- alu_mode3  out  1  0 = a+b, 1 = a-b (ALU negates b)
- alu_c  in  32  ALU result; combinational from alu_* within the same cycle

Behaviour:
- Reset values: all outputs, all state registers and cnt are 0; state = IDLE. Reset dominates any other event, including mid-operation; the partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → latch operands, cnt=0, go to RUN.
  - start=1 with op=1 and src_b==0 → go directly to DONE with dbz=1.
  - start=0 → hold.
- RUN: one iteration per cycle; cnt increments each cycle. After the cnt==31 iteration, go to DONE.
- DONE:
  - Write hi/lo, pulse done for one cycle, then return to IDLE.
  - start is not accepted in DONE; it is accepted in the following IDLE cycle.
- Latency:
  - Normal operation: done is high 33 cycles after the edge that sampled start (32 RUN + 1 DONE).
  - Divide-by-zero: done is high 1 cycle after that edge.
- start while busy or in DONE is ignored; there is no queueing.
- hi/lo/dbz change only in DONE; they hold their values otherwise.
- Multiply (registers acc[31:0], mq[31:0], mc[31:0]; initial acc=0, mq=src_b, mc=src_a):
  - ALU drive: alu_a=acc, alu_b=mc, alu_mode3=0.
  - Carry out: cy = (a31&b31) | ((a31|b31)&~c31).
  - If mq[0]=1: {acc,mq} ← {cy,alu_c,mq} >> 1.
  - If mq[0]=0: {acc,mq} ← {1'b0,acc,mq} >> 1.
  - Final result: hi=acc, lo=mq.
- Divide (registers rem, quo, dv; initial rem=0, quo=src_a, dv=src_b):
  - Form r={rem[30:0],quo[31]} and top=rem[31].
  - ALU drive: alu_a=r, alu_b=dv, alu_mode3=1.
  - Borrow: bw = (~a31&b31) | ((~a31|b31)&c31).
  - If top | ~bw: rem ← alu_c and qbit=1. Otherwise rem ← r and qbit=0.
  - quo ← {quo[30:0],qbit}.
  - Final result: hi=rem, lo=quo.
- Divide-by-zero result: hi=src_a, lo=32'hFFFFFFFF, dbz=1. dbz clears to 0 on the next completed operation that is not a divide-by-zero.
- When not busy, the alu_* outputs are 0.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- With the macro defined:
  - If op_signed=1, operands are converted to magnitude on accept (two's-complement negation done internally, not via the ALU).
  - The unsigned core runs unchanged.
  - In DONE, results are negated as required:
    - product when sign(a)^sign(b);
    - quotient when sign(a)^sign(b);
    - remainder when sign(a).
  - Latency is unchanged.
  - Divide-by-zero result is the same as unsigned.
- Without the macro: op_signed is ignored and all operations are unsigned.

Test Plan:
- Multiply 7 × 6, start at cycle 0 → done high at cycle 33, hi=0, lo=42, busy high for cycles 1–32.
- Multiply 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; alu_mode3 stays 0 throughout.
- Divide 100 / 7 → lo=14, hi=2, dbz=0. Then 0x80000000 / 3 → lo=0x2AAAAAAA, hi=2.
- Divide 5 / 0 → done at cycle 1, dbz=1, hi=5, lo=0xFFFFFFFF. A following 9/3 → dbz=0, lo=3, hi=0.
- Second start pulse at cycle 10 of a multiply → ignored; result unchanged. rst at cycle 20 of a later divide → next cycle busy=0, hi=lo=0, no done pulse.
- (MULDIV_SIGNED_EN) Signed −7 × 3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Signed −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
